// File: rtl/fpu_add_seq_pkg.sv
// Shared definitions for the sequential single-precision adder.
// Holds the IEEE-754 constants, the field widths used by every pipeline
// step, and the FSM state encoding. Imported by fpu_add_seq and fp_lzc.
package fpu_add_seq_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 2 * EXP_BIAS + 1;   // all-ones biased exponent

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int EXP_W   = 8;    // biased exponent
  localparam int FRAC_W  = 23;   // stored fraction
  localparam int MANT_W  = 24;   // fraction plus hidden bit
  localparam int ALIGN_W = 27;   // mantissa + guard + round + sticky
  localparam int SUM_W   = 28;   // aligned field plus carry-out
  localparam int LZC_W   = 5;    // enough to count 0..28
  localparam int NEXP_W  = 10;   // two's complement exponent during normalise

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    NORM   = 3'd4,
    PACK   = 3'd5
  } state_t;

endpackage

// File: rtl/fpu_add_seq_lzc.sv
// fp_lzc: purely combinational leading-zero counter for the 28-bit sum.
// Ports:
//   value  in  28  magnitude from the add step (bit 27 is the carry-out)
//   count  out 5   number of zeros above the most significant one; 28 when
//                  value is all zeros
module fp_lzc
  import fpu_add_seq_pkg::*;
(
  input  logic [SUM_W-1:0] value,
  output logic [LZC_W-1:0] count
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count = LZC_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (value[i]) count = LZC_W'(SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_add_seq.sv
// fpu_add_seq: multi-cycle IEEE-754 single-precision adder/subtractor.
// One operation walks IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> PACK -> IDLE;
// done is asserted in the PACK cycle, five cycles after the accepted start.
// Rounding: define FPU_ADD_RNE_EN for round-to-nearest-even, otherwise the
// result is truncated toward zero.
// Ports:
//   clk     in  1   rising-edge clock
//   reset   in  1   synchronous, active-low
//   start   in  1   request; accepted only while idle
//   op      in  1   0 = a+b, 1 = a-b
//   a, b    in  32  operands, captured on the accepted start edge
//   busy    out 1   high in UNPACK..NORM
//   done    out 1   one-cycle pulse in PACK; result/flags valid
//   result  out 32  packed sum, held between operations
//   flags   out 4   {N, Z, I(invalid), V(overflow)}, held between operations
// Handshake: start is sampled on a rising edge only when busy and done are
// both low; any start seen in another cycle is dropped, not queued.
module fpu_add_seq
  import fpu_add_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  // ------------------------------------------------------------ control FSM
  state_t state, state_nxt;
  logic   accept;

  assign accept = reset && (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == UNPACK) || (state == ALIGN) ||
                (state == ADD)    || (state == NORM);
  assign done = (state == PACK);

  // ------------------------------------------------------- captured operands
  logic [31:0] op_a, op_b;
  logic        op_sub;

  // ------------------------------------------------------------ UNPACK step
  logic              sign_b_eff;
  logic              a_exp_zero, b_exp_zero, a_exp_max, b_exp_max;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic              spec, spec_nxt;
  logic [31:0]       spec_res, spec_res_nxt;
  logic [3:0]        spec_flg, spec_flg_nxt;

  assign sign_b_eff = op_b[31] ^ op_sub;
  assign a_exp_zero = (op_a[30:23] == '0);
  assign b_exp_zero = (op_b[30:23] == '0);
  assign a_exp_max  = (op_a[30:23] == EXP_W'(EXP_MAX));
  assign b_exp_max  = (op_b[30:23] == EXP_W'(EXP_MAX));
  assign a_nan      = a_exp_max && (op_a[22:0] != '0);
  assign b_nan      = b_exp_max && (op_b[22:0] != '0);
  assign a_inf      = a_exp_max && (op_a[22:0] == '0);
  assign b_inf      = b_exp_max && (op_b[22:0] == '0);

  // Denormals become signed zero: exponent is already 0, mantissa cleared.
  assign mant_a = a_exp_zero ? '0 : {1'b1, op_a[FRAC_W-1:0]};
  assign mant_b = b_exp_zero ? '0 : {1'b1, op_b[FRAC_W-1:0]};

  always_comb begin
    spec_nxt     = 1'b1;
    spec_res_nxt = QNAN;
    spec_flg_nxt = 4'b0010;
    if (a_nan || b_nan) begin
      spec_nxt = 1'b1;
    end else if (a_inf && b_inf && (op_a[31] != sign_b_eff)) begin
      spec_nxt = 1'b1;
    end else if (a_inf) begin
      spec_res_nxt = POS_INF | {op_a[31], 31'd0};
      spec_flg_nxt = {op_a[31], 3'b000};
    end else if (b_inf) begin
      spec_res_nxt = POS_INF | {sign_b_eff, 31'd0};
      spec_flg_nxt = {sign_b_eff, 3'b000};
    end else begin
      spec_nxt = 1'b0;
    end
  end

  logic              u_sign_a, u_sign_b;
  logic [EXP_W-1:0]  u_exp_a, u_exp_b;
  logic [MANT_W-1:0] u_mant_a, u_mant_b;

  // ------------------------------------------------------------- ALIGN step
  logic                 swap;
  logic                 sign_l, sign_s;
  logic [EXP_W-1:0]     exp_l, exp_s, exp_diff;
  logic [MANT_W-1:0]    mant_l, mant_s;
  logic [LZC_W-1:0]     shamt;
  logic [2*ALIGN_W-1:0] shift_full;
  logic [ALIGN_W-1:0]   small_al;

  assign swap = {u_exp_b, u_mant_b} > {u_exp_a, u_mant_a};

  always_comb begin
    if (swap) begin
      sign_l = u_sign_b; exp_l = u_exp_b; mant_l = u_mant_b;
      sign_s = u_sign_a; exp_s = u_exp_a; mant_s = u_mant_a;
    end else begin
      sign_l = u_sign_a; exp_l = u_exp_a; mant_l = u_mant_a;
      sign_s = u_sign_b; exp_s = u_exp_b; mant_s = u_mant_b;
    end
  end

  assign exp_diff = exp_l - exp_s;
  // Past 27 positions the smaller operand can only ever reach sticky.
  assign shamt    = (exp_diff >= EXP_W'(ALIGN_W)) ? LZC_W'(ALIGN_W)
                                                  : exp_diff[LZC_W-1:0];
  // The lower half of the double-width shift catches every bit pushed out.
  assign shift_full = {mant_s, 3'b000, {ALIGN_W{1'b0}}} >> shamt;
  assign small_al   = {shift_full[2*ALIGN_W-1:ALIGN_W+1],
                       shift_full[ALIGN_W] | (|shift_full[ALIGN_W-1:0])};

  logic               al_sign, al_sub;
  logic [EXP_W-1:0]   al_exp;
  logic [ALIGN_W-1:0] al_large, al_small;

  // --------------------------------------------------------------- ADD step
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] ad_sum;

  // The swap guarantees large >= small, so subtraction never goes negative.
  assign sum = al_sub ? ({1'b0, al_large} - {1'b0, al_small})
                      : ({1'b0, al_large} + {1'b0, al_small});

  // -------------------------------------------------------------- NORM step
  logic [LZC_W-1:0]   lz_count, lshift;
  logic [ALIGN_W-1:0] norm_m;
  logic [NEXP_W-1:0]  norm_e;

  fp_lzc u_lzc (
    .value (ad_sum),
    .count (lz_count)
  );

  // Bit 27 clear means lz_count >= 1; the leading one belongs at bit 26.
  assign lshift = lz_count - LZC_W'(1);

  always_comb begin
    if (ad_sum[SUM_W-1]) begin
      norm_m = {ad_sum[SUM_W-1:2], ad_sum[1] | ad_sum[0]};
      norm_e = {2'b00, al_exp} + NEXP_W'(1);
    end else begin
      norm_m = ad_sum[ALIGN_W-1:0] << lshift;
      norm_e = {2'b00, al_exp} - {{(NEXP_W-LZC_W){1'b0}}, lshift};
    end
  end

  logic [ALIGN_W-1:0] nm_mant;
  logic [NEXP_W-1:0]  nm_exp;
  logic               nm_zero;

  // -------------------------------------------------------------- PACK step
  logic [MANT_W-1:0] pk_mant;
  logic [NEXP_W-1:0] pk_exp;
  logic              pk_ovf, pk_unf;
  logic [31:0]       pk_result;
  logic [3:0]        pk_flags;

`ifdef FPU_ADD_RNE_EN
  logic              rnd_inc;
  logic [MANT_W:0]   rounded;

  assign rnd_inc = nm_mant[2] & (nm_mant[1] | nm_mant[0] | nm_mant[3]);
  assign rounded = {1'b0, nm_mant[ALIGN_W-1:3]} + {{MANT_W{1'b0}}, rnd_inc};

  // A carry out of rounding leaves 1.000..0, so only the exponent moves.
  always_comb begin
    if (rounded[MANT_W]) begin
      pk_mant = rounded[MANT_W:1];
      pk_exp  = nm_exp + NEXP_W'(1);
    end else begin
      pk_mant = rounded[MANT_W-1:0];
      pk_exp  = nm_exp;
    end
  end
`else
  logic unused_grs;

  assign unused_grs = ^nm_mant[2:0];
  assign pk_mant    = nm_mant[ALIGN_W-1:3];
  assign pk_exp     = nm_exp;
`endif

  assign pk_ovf = !pk_exp[NEXP_W-1] && (pk_exp >= NEXP_W'(EXP_MAX));
  assign pk_unf = pk_exp[NEXP_W-1] || (pk_exp == '0);

  always_comb begin
    pk_result = 32'd0;
    pk_flags  = 4'b0100;
    if (spec) begin
      pk_result = spec_res;
      pk_flags  = spec_flg;
    end else if (nm_zero || pk_unf) begin
      pk_result = 32'd0;
      pk_flags  = 4'b0100;
    end else if (pk_ovf) begin
      pk_result = POS_INF | {al_sign, 31'd0};
      pk_flags  = {al_sign, 3'b001};
    end else begin
      pk_result = {al_sign, pk_exp[EXP_W-1:0], pk_mant[FRAC_W-1:0]};
      pk_flags  = {al_sign, 3'b000};
    end
  end

  // --------------------------------------------------------- datapath regs
  // Each step's registers are written only in that step's state and stay
  // stable until the next operation, so later steps read them directly.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a   <= a;
      op_b   <= b;
      op_sub <= op;
    end
    case (state)
      UNPACK: begin
        u_sign_a <= op_a[31];
        u_sign_b <= sign_b_eff;
        u_exp_a  <= op_a[30:23];
        u_exp_b  <= op_b[30:23];
        u_mant_a <= mant_a;
        u_mant_b <= mant_b;
        spec     <= spec_nxt;
        spec_res <= spec_res_nxt;
        spec_flg <= spec_flg_nxt;
      end
      ALIGN: begin
        al_sign  <= sign_l;
        al_sub   <= sign_l ^ sign_s;
        al_exp   <= exp_l;
        al_large <= {mant_l, 3'b000};
        al_small <= small_al;
      end
      ADD: begin
        ad_sum <= sum;
      end
      NORM: begin
        nm_mant <= norm_m;
        nm_exp  <= norm_e;
        nm_zero <= (ad_sum == '0);
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------- output regs
  logic [31:0] result_q;
  logic [3:0]  flags_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= 32'd0;
      flags_q  <= 4'b0000;
    end else if (state == PACK) begin
      result_q <= pk_result;
      flags_q  <= pk_flags;
    end
  end

  // The fresh value is shown in the done cycle itself and held afterwards.
  assign result = (state == PACK) ? pk_result : result_q;
  assign flags  = (state == PACK) ? pk_flags  : flags_q;

endmodule

// File: tb/tb_fpu_add_seq.sv
// Self-checking bench for fpu_add_seq. A real-arithmetic reference model
// produces the expected result/flags of each operation; a scoreboard process
// compares every done cycle against the expected queue and checks that the
// outputs hold while busy. Directed vectors pin the model with literals.
// Define FPU_ADD_RNE_EN for both bench and RTL to check the RNE build.
module tb_fpu_add_seq;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  flags;

  fpu_add_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  // ------------------------------------------------------------ clock/reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  expf_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    check(name, {31'd0, act}, {31'd0, req});
  endtask

  // ------------------------------------------------------- reference model
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction

  // Denormals count as zero; normals convert exactly into a double.
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Returns {flags, result}.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic [31:0] yy;
    real         s;
    logic [63:0] bits;
    int          e;
    logic [31:0] mant;
    logic        sg;
    yy = y ^ {sub, 31'd0};
    if (is_nan(x) || is_nan(yy)) return {4'b0010, 32'h7FC00000};
    if (is_inf(x) && is_inf(yy))
      return (x[31] == yy[31]) ? {x[31], 3'b000, x} : {4'b0010, 32'h7FC00000};
    if (is_inf(x))  return {x[31], 3'b000, x};
    if (is_inf(yy)) return {yy[31], 3'b000, yy};
    s = to_real(x) + to_real(yy);
    if (s == 0.0) return {4'b0100, 32'd0};
    bits = $realtobits(s);
    sg   = bits[63];
    e    = int'(bits[62:52]) - 1023 + 127;
    mant = {8'd0, 1'b1, bits[51:29]};
`ifdef FPU_ADD_RNE_EN
    if (bits[28] && ((|bits[27:0]) || mant[0])) mant = mant + 1;
    if (mant == 32'h0100_0000) begin
      mant = 32'h0080_0000;
      e    = e + 1;
    end
`endif
    if (e >= 255) return {sg, 3'b001, sg, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0100, 32'd0};
    return {sg, 3'b000, sg, e[7:0], mant[22:0]};
  endfunction

  // ------------------------------------------------------------ scoreboard
  logic [31:0] held_result = 32'd0;
  logic [3:0]  held_flags  = 4'd0;

  always @(negedge clk) begin : scoreboard
    logic [31:0] r;
    logic [3:0]  f;
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 with result %h, required no pending operation", result);
      end else begin
        r = exp_q.pop_front();
        f = expf_q.pop_front();
        check("result", result, r);
        check("flags", {28'd0, flags}, {28'd0, f});
      end
    end
    if (reset === 1'b1 && busy === 1'b1) begin
      check("hold_result", result, held_result);
      check("hold_flags", {28'd0, flags}, {28'd0, held_flags});
    end
    if (busy !== 1'b1) begin
      held_result = result;
      held_flags  = flags;
    end
  end

  // --------------------------------------------------------------- drivers
  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vop, input bit repulse);
    @(posedge clk); #1;
    a = va; b = vb; op = vop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'h4049_0FDB; b = 32'hC000_0000; op = ~vop;  // must not be resampled
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check1($sformatf("busy_cycle%0d", c), busy, c < 5);
      check1($sformatf("done_cycle%0d", c), done, c == 5);
      if (repulse) start = (c == 2);
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic vop, input bit lit_en, input logic [31:0] lit_res,
                         input logic [3:0] lit_flg, input bit repulse);
    logic [35:0] m;
    m = model(va, vb, vop);
    if (lit_en) begin
      check({name, "_model_result"}, m[31:0], lit_res);
      check({name, "_model_flags"}, {28'd0, m[35:32]}, {28'd0, lit_flg});
    end
    exp_q.push_back(m[31:0]);
    expf_q.push_back(m[35:32]);
    issue(va, vb, vop, repulse);
  endtask

  // ------------------------------------------------------------- stimulus
  localparam logic [31:0] RND_RES  = `ifdef FPU_ADD_RNE_EN 32'h3F800002 `else 32'h3F800001 `endif;
  localparam logic [31:0] TIE_RES  = `ifdef FPU_ADD_RNE_EN 32'h3F800000 `else 32'h3F7FFFFF `endif;
  localparam logic [31:0] BIG_RES  = `ifdef FPU_ADD_RNE_EN 32'h4B800001 `else 32'h4B800000 `endif;

  initial begin
    logic [35:0] m;
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;

    // Reset state, including a start that coincides with reset low.
    @(posedge clk); #1;
    start = 1'b1; a = 32'h3F80_0000; b = 32'h4000_0000;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check("reset_result", result, 32'd0);
    check("reset_flags", {28'd0, flags}, 32'd0);
    repeat (2) @(negedge clk);
    check1("start_in_reset_ignored", busy, 1'b0);

    run_vec("basic_add",   32'h3F800000, 32'h40000000, 1'b0, 1, 32'h40400000, 4'b0000, 0);
    run_vec("cancel",      32'h3F800000, 32'h3F800000, 1'b1, 1, 32'h00000000, 4'b0100, 1);
    repeat (8) @(negedge clk);  // any second done would be caught here
    run_vec("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 1, 32'h7FC00000, 4'b0010, 0);
    run_vec("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1, 32'h7F800000, 4'b0001, 0);
    run_vec("round",       32'h3F800001, 32'h33800000, 1'b0, 1, RND_RES,      4'b0000, 0);
    run_vec("round_tie",   32'h3F800000, 32'h33000000, 1'b1, 1, TIE_RES,      4'b0000, 0);
    run_vec("round_big",   32'h4B800000, 32'h3FC00000, 1'b0, 1, BIG_RES,      4'b0000, 0);
    run_vec("sub_neg",     32'h40400000, 32'h40A00000, 1'b1, 1, 32'hC0000000, 4'b1000, 0);
    run_vec("mixed_sign",  32'h41200000, 32'hC1A00000, 1'b0, 1, 32'hC1200000, 4'b1000, 0);
    run_vec("nan_in",      32'h7FC00001, 32'h3F800000, 1'b0, 1, 32'h7FC00000, 4'b0010, 0);
    run_vec("neg_inf",     32'hFF800000, 32'h3F800000, 1'b0, 1, 32'hFF800000, 4'b1000, 0);
    run_vec("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 1, 32'h7FC00000, 4'b0010, 0);
    run_vec("denorm_in",   32'h00000001, 32'h3F800000, 1'b0, 1, 32'h3F800000, 4'b0000, 0);
    run_vec("underflow",   32'h00800001, 32'h00800000, 1'b1, 1, 32'h00000000, 4'b0100, 0);
    run_vec("pt1_pt2",     32'h3DCCCCCD, 32'h3E4CCCCD, 1'b0, 0, 32'd0, 4'd0, 0);
    run_vec("pi_e",        32'h40490FDB, 32'h402DF854, 1'b0, 0, 32'd0, 4'd0, 0);
    run_vec("one_m_pt1",   32'h3F800000, 32'h3DCCCCCD, 1'b1, 0, 32'd0, 4'd0, 0);

    // Reset abort: reset falls in the ALIGN cycle; no done, outputs cleared.
    @(posedge clk); #1;
    a = 32'h3F80_0000; b = 32'h4000_0000; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check("abort_result", result, 32'd0);
    check("abort_flags", {28'd0, flags}, 32'd0);
    // New start in the first cycle after release.
    reset = 1'b1; start = 1'b1; a = 32'h4040_0000; b = 32'h40A0_0000; op = 1'b1;
    m = model(a, b, op);
    exp_q.push_back(m[31:0]);
    expf_q.push_back(m[35:32]);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check1($sformatf("post_reset_busy%0d", c), busy, c < 5);
      check1($sformatf("post_reset_done%0d", c), done, c == 5);
    end

    repeat (4) @(negedge clk);
    check("pending_results", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
